// File: rtl/router_port_rx_if.sv
// rtl/router_port_rx_if.sv - byte stream out of the router port receiver
// master drives data/last/valid, slave returns ready.
interface router_port_rx_if;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_last,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_last,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/router_port_rx.sv
// rtl/router_port_rx.sv - serial router output port to byte FIFO receiver
// Rebuilds LSB-first bytes from frameo_n/valido_n/dout and buffers them first-word-fall-through.
module router_port_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frameo_n,
  input  logic              valido_n,
  input  logic              dout,
  router_port_rx_if.master  byte_if,
  output logic              pkt_error,
  output logic              overflow,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic             frame_s0_q, frame_s0_d;
  logic             valid_s0_q, valid_s0_d;
  logic             dout_s0_q, dout_s0_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic             pkt_error_q, pkt_error_d;
  logic             overflow_q, overflow_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [8:0]       mem_q [FIFO_DEPTH];

  logic       active;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       full;
  logic       empty;
  logic [8:0] push_entry;
  logic [8:0] head_entry;

  always_comb begin
    frame_s0_d = frameo_n;
    valid_s0_d = valido_n;
    dout_s0_d  = dout;
  end

  // The input stage keeps sampling through reset so DRAIN sees the live frame.
  always_ff @(posedge clock) begin
    frame_s0_q <= frame_s0_d;
    valid_s0_q <= valid_s0_d;
    dout_s0_q  <= dout_s0_d;
  end

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop   = !empty && byte_if.byte_ready;

    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    pkt_count_d = pkt_count_q;
    pkt_error_d = 1'b0;
    push_req    = 1'b0;
    push_entry  = 9'd0;
    active      = (state_q == ST_RECV) || ((state_q == ST_IDLE) && !frame_s0_q);

    if (state_q == ST_DRAIN) begin
      if (frame_s0_q) begin
        state_d = ST_IDLE;
      end
    end else if (active) begin
      state_d = ST_RECV;
      if (!valid_s0_q) begin
        shift_d[cnt_q] = dout_s0_q;
        if (cnt_q == 3'd7) begin
          push_req   = 1'b1;
          push_entry = {frame_s0_q, shift_d};
          cnt_d      = 3'd0;
          if (frame_s0_q) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
            state_d     = ST_IDLE;
          end
        end else if (frame_s0_q) begin
          pkt_error_d = 1'b1;
          cnt_d       = 3'd0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end else if (frame_s0_q) begin
        // Frame ended on a gap: covers both a truncated byte and an empty frame.
        pkt_error_d = 1'b1;
        cnt_d       = 3'd0;
        state_d     = ST_IDLE;
      end
    end

    push_ok    = push_req && (!full || pop);
    overflow_d = overflow_q || (push_req && !push_ok);
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_DRAIN;
      cnt_q       <= 3'd0;
      shift_q     <= 8'd0;
      pkt_count_q <= '0;
      pkt_error_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      pkt_count_q <= pkt_count_d;
      pkt_error_q <= pkt_error_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end
  end

  always_comb begin
    head_entry = empty ? 9'd0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  assign byte_if.byte_data  = head_entry[7:0];
  assign byte_if.byte_last  = head_entry[8];
  assign byte_if.byte_valid = !empty;
  assign pkt_error          = pkt_error_q;
  assign overflow           = overflow_q;
  assign pkt_count          = pkt_count_q;

endmodule

// File: tb/tb_router_port_rx.sv
// tb/tb_router_port_rx.sv - self-checking bench for router_port_rx
// Drives serial packets and compares popped bytes, counters and flags against a packet-level model.
module tb_router_port_rx;

  localparam int DEPTH = 16;
  localparam int CW    = 8;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          frameo_n = 1'b1;
  logic          valido_n = 1'b1;
  logic          dout     = 1'b0;
  logic          pkt_error;
  logic          overflow;
  logic [CW-1:0] pkt_count;

  router_port_rx_if bif ();

  router_port_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .frameo_n  (frameo_n),
    .valido_n  (valido_n),
    .dout      (dout),
    .byte_if   (bif),
    .pkt_error (pkt_error),
    .overflow  (overflow),
    .pkt_count (pkt_count)
  );

  always #5 clock = ~clock;

  int         checks    = 0;
  int         errors    = 0;
  int         err_seen  = 0;
  int         exp_err   = 0;
  int         exp_count = 0;
  bit         rand_ready = 1'b0;
  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];

  // Consumer side: record every accepted beat and every error pulse.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bif.byte_valid && bif.byte_ready) got_q.push_back({bif.byte_last, bif.byte_data});
      if (pkt_error) err_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic f, input logic v, input logic d);
    frameo_n = f;
    valido_n = v;
    dout     = d;
    if (rand_ready) bif.byte_ready = 1'($urandom_range(0, 1));
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last_byte, input int gap_pct);
    for (int i = 0; i < 8; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) drive(1'b0, 1'b1, 1'b0);
      drive((last_byte && i == 7) ? 1'b1 : 1'b0, 1'b0, b[i]);
    end
  endtask

  // Well-formed packet: every byte lands with last only on the final one, count bumps once.
  task automatic send_packet(input logic [7:0] bytes [$], input int gap_pct);
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], i == bytes.size() - 1, gap_pct);
      exp_q.push_back({(i == bytes.size() - 1) ? 1'b1 : 1'b0, bytes[i]});
    end
    exp_count = (exp_count + 1) % (1 << CW);
    frameo_n = 1'b1;
    valido_n = 1'b1;
  endtask

  task automatic drain();
    bif.byte_ready = 1'b1;
    for (int k = 0; k < 400 && (got_q.size() < exp_q.size() || bif.byte_valid); k++) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bif.byte_ready = 1'b0;
    idle(3);
    @(negedge clock);
    checks++; if (bif.byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bif.byte_valid); end
    checks++; if (bif.byte_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bif.byte_data); end
    checks++; if (bif.byte_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", bif.byte_last); end
    checks++; if (pkt_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", pkt_error); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (pkt_count !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", pkt_count); end
    reset_n = 1'b1;
    exp_count = 0;
    idle(3);
  endtask

  task automatic test_single();
    logic [7:0] pk [$];
    exp_q.delete(); got_q.delete();
    bif.byte_ready = 1'b0;
    pk = '{8'hA5};
    send_packet(pk, 0);
    @(negedge clock);
    checks++; if (bif.byte_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", bif.byte_valid); end
    @(negedge clock);
    checks++; if (bif.byte_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bif.byte_valid); end
    checks++; if ({bif.byte_last, bif.byte_data} !== 9'h1A5) begin errors++; $display("FAIL single_beat got %h exp 1a5", {bif.byte_last, bif.byte_data}); end
    checks++; if (pkt_count !== CW'(exp_count)) begin errors++; $display("FAIL single_cnt got %0d exp %0d", pkt_count, exp_count); end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_len got %0d exp %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_stall();
    logic [7:0] pk [$];
    logic [8:0] head;
    exp_q.delete(); got_q.delete();
    bif.byte_ready = 1'b0;
    pk = '{8'h01, 8'h80, 8'hFF, 8'h3C};
    send_packet(pk, 40);
    idle(2);
    @(negedge clock);
    head = {bif.byte_last, bif.byte_data};
    checks++; if (head !== exp_q[0]) begin errors++; $display("FAIL stall_head got %h exp %h", head, exp_q[0]); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (!bif.byte_valid || {bif.byte_last, bif.byte_data} !== head) begin
        errors++; $display("FAIL stall_stable got %h exp %h", {bif.byte_last, bif.byte_data}, head);
      end
    end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_errors();
    logic [7:0] b;
    exp_q.delete(); got_q.delete();
    bif.byte_ready = 1'b1;
    b = 8'h5A;
    send_byte(b, 1'b0, 0);
    exp_q.push_back({1'b0, b});
    for (int i = 0; i < 4; i++) drive((i == 3) ? 1'b1 : 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    exp_err++;
    idle(4);
    checks++; if (err_seen != exp_err) begin errors++; $display("FAIL partial_err got %0d exp %0d", err_seen, exp_err); end
    checks++; if (pkt_count !== CW'(exp_count)) begin errors++; $display("FAIL partial_cnt got %0d exp %0d", pkt_count, exp_count); end
    drain();
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL partial_beat got %0d beats head %h exp %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0, exp_q[0]); end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    exp_err++;
    idle(4);
    checks++; if (err_seen != exp_err) begin errors++; $display("FAIL abort_err got %0d exp %0d", err_seen, exp_err); end
    checks++; if (bif.byte_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", bif.byte_valid); end
  endtask

  task automatic test_random();
    logic [7:0] pk [$];
    exp_q.delete(); got_q.delete();
    rand_ready = 1'b1;
    for (int p = 0; p < 12; p++) begin
      pk.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) pk.push_back(8'($urandom));
      send_packet(pk, 20);
      idle($urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    drain();
    checks++; if (pkt_count !== CW'(exp_count)) begin errors++; $display("FAIL random_cnt got %0d exp %0d", pkt_count, exp_count); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL random_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] pk [$];
    exp_q.delete(); got_q.delete();
    bif.byte_ready = 1'b0;
    for (int i = 0; i < 20; i++) pk.push_back(8'($urandom));
    send_packet(pk, 0);
    // With no consumer, only the first DEPTH bytes can be held; the rest are dropped.
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    idle(3);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (pkt_count !== CW'(exp_count)) begin errors++; $display("FAIL ovf_cnt got %0d exp %0d", pkt_count, exp_count); end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b [4];
    logic [7:0] pk [$];
    int         err_before;
    exp_q.delete(); got_q.delete();
    bif.byte_ready = 1'b0;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    send_byte(b[0], 1'b0, 0);
    send_byte(b[1], 1'b0, 0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, b[2][i]);
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    reset_n = 1'b1;
    exp_count = 0;
    err_before = err_seen;
    for (int i = 6; i < 8; i++) drive(1'b0, 1'b0, b[2][i]);
    send_byte(b[3], 1'b1, 0);
    idle(3);
    @(negedge clock);
    checks++; if (bif.byte_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bif.byte_valid); end
    checks++; if (pkt_count !== '0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", pkt_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b exp 0", overflow); end
    checks++; if (err_seen != err_before) begin errors++; $display("FAIL rstmid_err got %0d exp %0d", err_seen, err_before); end
    pk = '{8'($urandom), 8'($urandom), 8'($urandom)};
    send_packet(pk, 10);
    drain();
    checks++; if (pkt_count !== CW'(exp_count)) begin errors++; $display("FAIL rstmid_cnt2 got %0d exp %0d", pkt_count, exp_count); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] pk [$];
    exp_q.delete(); got_q.delete();
    bif.byte_ready = 1'b1;
    while (exp_count != (1 << CW) - 1) begin
      pk = '{8'($urandom)};
      send_packet(pk, 0);
      idle(1);
    end
    idle(2);
    checks++; if (pkt_count !== CW'(exp_count)) begin errors++; $display("FAIL wrap_max got %0d exp %0d", pkt_count, exp_count); end
    pk = '{8'($urandom)};
    send_packet(pk, 0);
    idle(3);
    checks++; if (pkt_count !== '0 || exp_count != 0) begin errors++; $display("FAIL wrap_zero got %0d exp %0d", pkt_count, exp_count); end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        checks++; errors++; $display("FAIL wrap_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end else begin
        checks++;
      end
    end
  endtask

  initial begin
    bif.byte_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_errors();
    test_random();
    test_overflow();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
